// File: rtl/seg7_frame_if.sv
// seg7_frame_if: valid/ready frame bus carrying recovered
// hex digits and their per-digit blank flags.
interface seg7_frame_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] frame_data_o;
    logic [NUM_DIGITS-1:0]   frame_blank_o;
    logic                    frame_valid_o;
    logic                    frame_ready_i;

    modport master (
        output frame_data_o,
        output frame_blank_o,
        output frame_valid_o,
        input  frame_ready_i
    );

    modport slave (
        input  frame_data_o,
        input  frame_blank_o,
        input  frame_valid_o,
        output frame_ready_i
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers hex digits from a scanned,
// active-low 7-segment bus and publishes checked frames.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_n,
    input  logic [NUM_DIGITS-1:0] an_n,
    seg7_frame_if.master          frame,
    output logic                  err_pulse_o,
    output logic                  ovf_pulse_o
);
    localparam int SW = NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    state_t                state;
    state_t                state_next;
    logic [SW-1:0]         sync1;
    logic [SW-1:0]         sync2;
    logic [SW-1:0]         prev;
    logic [CW-1:0]         cnt;
    logic [NUM_DIGITS-1:0] an;
    logic [6:0]            seg;
    logic                  change;
    logic                  one_hot;
    logic                  capture;
    logic                  done;
    logic                  err_next;
    logic [5:0]            dec;
    logic [NUM_DIGITS-1:0] hit;
    logic [DW-1:0]         work_nib;
    logic [DW-1:0]         work_nib_next;
    logic [NUM_DIGITS-1:0] work_blank;
    logic [NUM_DIGITS-1:0] work_blank_next;
    logic [NUM_DIGITS-1:0] seen;
    logic [NUM_DIGITS-1:0] seen_upd;
    logic [NUM_DIGITS-1:0] seen_next;
    logic [DW-1:0]         data;
    logic [NUM_DIGITS-1:0] blank;
    logic                  valid;
    logic                  err;
    logic                  ovf;

    // {accepted, blank, nibble}; accepted=0 flags an illegal pattern
    function automatic logic [5:0] decode(input logic [6:0] p);
        logic [5:0] r;
        r = 6'b0;
        case (p)
            7'h40:   r = {2'b10, 4'h0};
            7'h79:   r = {2'b10, 4'h1};
            7'h24:   r = {2'b10, 4'h2};
            7'h30:   r = {2'b10, 4'h3};
            7'h19:   r = {2'b10, 4'h4};
            7'h12:   r = {2'b10, 4'h5};
            7'h02:   r = {2'b10, 4'h6};
            7'h78:   r = {2'b10, 4'h7};
            7'h00:   r = {2'b10, 4'h8};
            7'h10:   r = {2'b10, 4'h9};
            7'h08:   r = {2'b10, 4'hA};
            7'h03:   r = {2'b10, 4'hB};
            7'h46:   r = {2'b10, 4'hC};
            7'h21:   r = {2'b10, 4'hD};
            7'h06:   r = {2'b10, 4'hE};
            7'h0E:   r = {2'b10, 4'hF};
            7'h7F:   r = {2'b11, 4'h0};
            default: r = 6'b0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
            cnt   <= '0;
            state <= IDLE;
        end else begin
            sync1 <= {an_n, seg_n};
            sync2 <= sync1;
            prev  <= sync2;
            state <= state_next;
            if (change) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_comb begin
        state_next      = state;
        work_nib_next   = work_nib;
        work_blank_next = work_blank;
        seen_upd        = seen;
        err_next        = 1'b0;
        an      = sync2[SW-1:7];
        seg     = sync2[6:0];
        change  = (sync2 != prev);
        one_hot = ($countones(~an) == 1);
        hit     = one_hot ? ~an : '0;
        capture = (state == SETTLE) && !change && (cnt == CNT_MAX);
        dec     = decode(seg);

        unique case (state)
            IDLE: begin
                if (one_hot) state_next = SETTLE;
            end
            SETTLE: begin
                if (change) state_next = one_hot ? SETTLE : IDLE;
                else if (capture) state_next = HELD;
            end
            HELD: begin
                if (change) state_next = one_hot ? SETTLE : IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (capture) begin
            if (dec[5]) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (hit[k]) begin
                        work_nib_next[4*k +: 4] = dec[3:0];
                        work_blank_next[k]      = dec[4];
                    end
                end
                seen_upd = seen | hit;
            end else begin
                err_next = 1'b1;
            end
        end

        done      = &seen_upd;
        seen_next = done ? '0 : seen_upd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work_nib   <= '0;
            work_blank <= '0;
            seen       <= '0;
            data       <= '0;
            blank      <= '0;
            valid      <= 1'b0;
            err        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            work_nib   <= work_nib_next;
            work_blank <= work_blank_next;
            seen       <= seen_next;
            err        <= err_next;
            ovf        <= 1'b0;
            // a finished frame may replace one being accepted this cycle
            if (done) begin
                if (!valid || frame.frame_ready_i) begin
                    data  <= work_nib_next;
                    blank <= work_blank_next;
                    valid <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (valid && frame.frame_ready_i) begin
                valid <= 1'b0;
            end
        end
    end

    assign frame.frame_data_o  = data;
    assign frame.frame_blank_o = blank;
    assign frame.frame_valid_o = valid;
    assign err_pulse_o         = err;
    assign ovf_pulse_o         = ovf;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: table vectors, corner sequences and
// randomized frames checked against a lookup-table model.
module tb_seg7_scan_decoder;
    localparam int ND = 4;
    localparam int SC = 8;

    typedef struct {
        logic [ND-1:0][6:0] seg;
        logic [15:0]        data;
        logic [3:0]         blank;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    seg_n;
    logic [ND-1:0] an_n;
    logic          err_pulse_o;
    logic          ovf_pulse_o;

    int checks = 0;
    int fails  = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;

    vec_t       vecs [5];
    logic [6:0] hex_pat [16];

    seg7_frame_if #(.NUM_DIGITS(ND)) frame ();

    seg7_scan_decoder #(
        .NUM_DIGITS   (ND),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .frame      (frame),
        .err_pulse_o(err_pulse_o),
        .ovf_pulse_o(ovf_pulse_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (err_pulse_o === 1'b1) err_cnt <= err_cnt + 1;
        if (ovf_pulse_o === 1'b1) ovf_cnt <= ovf_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic show(input int k, input logic [6:0] p, input int n);
        logic [ND-1:0] one;
        one   = 1;
        an_n  = ~(one << k);
        seg_n = p;
        repeat (n) tick();
    endtask

    task automatic idle(input int n);
        an_n  = '1;
        seg_n = 7'h7F;
        repeat (n) tick();
    endtask

    task automatic scan_vec(input vec_t v);
        for (int k = 0; k < ND; k++) show(k, v.seg[k], 20);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (frame.frame_valid_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({name, "_valid"}, 32'(frame.frame_valid_o), 1);
    endtask

    task automatic expect_frame(input string name, input logic [15:0] d,
                                input logic [3:0] b);
        wait_valid(name);
        check({name, "_data"}, 32'(frame.frame_data_o), 32'(d));
        check({name, "_blank"}, 32'(frame.frame_blank_o), 32'(b));
        frame.frame_ready_i = 1'b1;
        tick();
        frame.frame_ready_i = 1'b0;
        check({name, "_drop"}, 32'(frame.frame_valid_o), 0);
    endtask

    initial begin
        int ord [ND];
        int j;
        int t;
        int idx;
        logic [15:0] ed;
        logic [3:0]  eb;
        logic [ND-1:0][6:0] ps;

        hex_pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        vecs[0] = '{seg: {7'h19, 7'h30, 7'h24, 7'h79}, data: 16'h4321, blank: 4'h0};
        vecs[1] = '{seg: {7'h0E, 7'h7F, 7'h03, 7'h08}, data: 16'hF0BA, blank: 4'b0100};
        vecs[2] = '{seg: {7'h21, 7'h46, 7'h40, 7'h00}, data: 16'hDC08, blank: 4'h0};
        vecs[3] = '{seg: {7'h7F, 7'h7F, 7'h7F, 7'h7F}, data: 16'h0000, blank: 4'hF};
        vecs[4] = '{seg: {7'h02, 7'h78, 7'h06, 7'h10}, data: 16'h67E9, blank: 4'h0};

        rst_n = 1'b0;
        frame.frame_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seg_n = 7'($urandom);
            an_n  = ND'($urandom);
            tick();
            check("reset_outputs",
                  32'({frame.frame_data_o, frame.frame_blank_o,
                       frame.frame_valid_o, err_pulse_o, ovf_pulse_o}), 0);
        end
        an_n  = '1;
        seg_n = 7'h7F;
        rst_n = 1'b1;
        idle(20);
        check("idle_valid", 32'(frame.frame_valid_o), 0);

        for (int v = 0; v < 5; v++) begin
            scan_vec(vecs[v]);
            idle(3);
            expect_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].blank);
        end

        // short pattern must not capture; long illegal one pulses err
        idle(5);
        show(0, 7'h40, SC - 1);
        show(0, 7'h7E, 20);
        check("glitch_err_once", 32'(err_cnt), 1);
        show(1, 7'h24, 20);
        show(2, 7'h30, 20);
        show(3, 7'h19, 20);
        idle(5);
        check("err_seen_kept", 32'(frame.frame_valid_o), 0);
        show(0, 7'h12, 20);
        idle(3);
        expect_frame("after_err", 16'h4325, 4'h0);

        // overflow: second frame dropped while first waits
        scan_vec(vecs[0]);
        idle(3);
        wait_valid("ovf_first");
        scan_vec(vecs[2]);
        idle(15);
        check("ovf_keep_data", 32'(frame.frame_data_o), 32'h4321);
        check("ovf_keep_valid", 32'(frame.frame_valid_o), 1);
        check("ovf_count", 32'(ovf_cnt), 1);
        for (int k = 0; k < ND - 1; k++) show(k, vecs[4].seg[k], 20);
        show(ND - 1, vecs[4].seg[ND-1], 10);
        frame.frame_ready_i = 1'b1;
        tick();
        frame.frame_ready_i = 1'b0;
        check("swap_valid", 32'(frame.frame_valid_o), 1);
        check("swap_data", 32'(frame.frame_data_o), 32'h67E9);
        check("swap_no_ovf", 32'(ovf_cnt), 1);
        repeat (9) tick();
        idle(3);
        expect_frame("swap", 16'h67E9, 4'h0);

        // reset mid-frame discards pending and partial frames
        scan_vec(vecs[3]);
        idle(3);
        wait_valid("pend");
        show(0, 7'h79, 20);
        show(1, 7'h24, 20);
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        idle(5);
        check("rst_mid_valid", 32'(frame.frame_valid_o), 0);
        show(2, vecs[4].seg[2], 20);
        show(3, vecs[4].seg[3], 20);
        show(0, vecs[4].seg[0], 20);
        show(1, vecs[4].seg[1], 20);
        idle(3);
        expect_frame("rst_new", 16'h67E9, 4'h0);

        for (int f = 0; f < 15; f++) begin
            for (int i = 0; i < ND; i++) ord[i] = i;
            for (int i = ND - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = ord[i];
                ord[i] = ord[j];
                ord[j] = t;
            end
            ed = '0;
            eb = '0;
            for (int i = 0; i < ND; i++) begin
                idx = $urandom_range(0, 16);
                ps[ord[i]] = (idx < 16) ? hex_pat[idx] : 7'h7F;
                ed[4*ord[i] +: 4] = (idx < 16) ? 4'(idx) : 4'h0;
                eb[ord[i]] = (idx == 16);
            end
            for (int i = 0; i < ND; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    show($urandom_range(0, ND - 1), 7'($urandom),
                         $urandom_range(1, SC - 1));
                end
                show(ord[i], ps[ord[i]], $urandom_range(12, 20));
            end
            idle(3);
            expect_frame($sformatf("rand%0d", f), ed, eb);
        end

        check("final_err_count", 32'(err_cnt), 1);
        check("final_ovf_count", 32'(ovf_cnt), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
